seq_divider: RTL

//  Multi-cycle restoring divider, the inverse of the 4x4 array multiplier:

---
 rtl/seq_divider_pkg.sv | 19 +
 rtl/seq_divider_if.sv | 28 ++
 rtl/seq_divider_div_step.sv | 34 +++
 rtl/seq_divider.sv | 105 ++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One quotient bit is produced per dividend bit.
  function automatic int iter_count(input int n);
    return 2 * n;
  endfunction

  localparam int ITERS_DEF = 2 * N_DEF;

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done divider handshake with operands, results and FSM debug state.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
);
  // start is sampled only when the divider is idle or done; operands are captured
  // on that same edge. done is a one-cycle pulse; results and div_by_zero then hold.
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  state_t         dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module seq_divider_div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] divisor,
  input  logic         bit_in,
  output logic [N-1:0] r_out,
  output logic         qbit
);
  logic [N:0]   a;
  logic [N:0]   b;
  logic [N+1:0] c;
  logic [N-1:0] diff;

  // a - b computed as a + ~b + 1; carry out of the top cell means no borrow.
  assign a    = {r, bit_in};
  assign b    = ~{1'b0, divisor};
  assign c[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_fa
      assign diff[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  endgenerate

  // The top cell's sum is always zero when the subtract succeeds, so only its carry is kept.
  assign c[N + 1] = (a[N] & b[N]) | (a[N] & c[N]) | (b[N] & c[N]);
  assign qbit     = c[N + 1];
  assign r_out    = qbit ? diff : a[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input logic        clk,
  input logic        rst_n,
  seq_divider_if.slave bus
);
  localparam int              CNT_W = $clog2(2 * N + 1);
  localparam int              ITERS = iter_count(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  state_t         state, state_nxt;
  logic           accept, zero_div, last_iter;
  logic           dz_pend;
  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0] dvd_sh, q_sh;
  logic [N-1:0]   dvs_q, r_q, r_nxt;
  logic           qbit;
  logic           done_q, dbz_q;
  logic [2*N-1:0] quot_q;
  logic [N-1:0]   rem_q;

  seq_divider_div_step #(.N(N)) u_step (
    .r       (r_q),
    .divisor (dvs_q),
    .bit_in  (dvd_sh[2*N-1]),
    .r_out   (r_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A divide-by-zero spends one cycle in DONE with dz_pend set before it reports.
  always_comb begin
    accept    = bus.start && ((state == ST_IDLE) || ((state == ST_DONE) && !dz_pend));
    zero_div  = (bus.divisor == '0);
    last_iter = (cnt == LAST);
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (accept) state_nxt = zero_div ? ST_DONE : ST_CALC;
      ST_CALC: if (last_iter) state_nxt = ST_DONE;
      ST_DONE: begin
        if (accept)        state_nxt = zero_div ? ST_DONE : ST_CALC;
        else if (!dz_pend) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_sh  <= '0;
      dvs_q   <= '0;
      q_sh    <= '0;
      r_q     <= '0;
      cnt     <= '0;
      dz_pend <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        dvd_sh  <= bus.dividend;
        dvs_q   <= bus.divisor;
        q_sh    <= '0;
        r_q     <= '0;
        cnt     <= '0;
        dz_pend <= zero_div;
        dbz_q   <= 1'b0;
      end else if (state == ST_CALC) begin
        dvd_sh <= {dvd_sh[2*N-2:0], 1'b0};
        q_sh   <= {q_sh[2*N-2:0], qbit};
        r_q    <= r_nxt;
        cnt    <= cnt + CNT_W'(1);
        if (last_iter) begin
          done_q <= 1'b1;
          quot_q <= {q_sh[2*N-2:0], qbit};
          rem_q  <= r_nxt;
        end
      end else if (dz_pend) begin
        dz_pend <= 1'b0;
        done_q  <= 1'b1;
        dbz_q   <= 1'b1;
        quot_q  <= '1;
        rem_q   <= dvd_sh[N-1:0];
      end
    end
  end

  assign bus.busy        = (state == ST_CALC);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dbg_state   = state;

endmodule
